// File: rtl/schmitt_trigger_bank_if.sv
// Handshake-free signal bundle for schmitt_trigger_bank: raw inputs and soft clear
// from the controller, filtered levels, edge strobes and ready back from the bank.
interface schmitt_trigger_bank_if #(
  parameter int unsigned p_CHANNELS = 8
);
  logic                  i_clr;
  logic [p_CHANNELS-1:0] i_in;
  logic [p_CHANNELS-1:0] o_out;
  logic [p_CHANNELS-1:0] o_rise;
  logic [p_CHANNELS-1:0] o_fall;
  logic                  o_ready;

  modport master (output i_clr, i_in, input o_out, o_rise, o_fall, o_ready);
  modport slave  (input i_clr, i_in, output o_out, o_rise, o_fall, o_ready);
endinterface

// File: rtl/schmitt_trigger_bank.sv
// Multi-channel hysteresis debouncer: optional synchroniser, per-channel rise/fall
// filter FSMs, registered levels and one-cycle edge strobes.
module schmitt_trigger_bank #(
  parameter int unsigned p_CHANNELS    = 8,
  parameter int unsigned p_RISE_FILTER = 5,
  parameter int unsigned p_FALL_FILTER = 5,
  parameter int unsigned p_SYNC_STAGES = 2
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  schmitt_trigger_bank_if.slave  bus
);

  localparam int unsigned MAX_FILT = (p_RISE_FILTER > p_FALL_FILTER) ? p_RISE_FILTER : p_FALL_FILTER;
  localparam int unsigned CW       = $clog2(MAX_FILT + 1);
  localparam int unsigned IW       = $clog2(p_SYNC_STAGES + 2);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] RISE_LAST = CW'(p_RISE_FILTER - 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(p_FALL_FILTER - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(p_SYNC_STAGES);

  typedef enum logic [2:0] {
    START = 3'd0,
    LOW   = 3'd1,
    RISE  = 3'd2,
    HIGH  = 3'd3,
    FALL  = 3'd4
  } state_t;

  logic [p_CHANNELS-1:0] s;

  generate
    if (p_SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.i_in;
    end else begin : g_sync
      logic [p_CHANNELS-1:0] chain_q [p_SYNC_STAGES];

      // Not affected by i_clr: only the hard reset empties the chain.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < p_SYNC_STAGES; i++) chain_q[i] <= '0;
        end else begin
          chain_q[0] <= bus.i_in;
          for (int unsigned i = 1; i < p_SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
        end
      end

      assign s = chain_q[p_SYNC_STAGES-1];
    end
  endgenerate

  logic [IW-1:0] init_cnt_q;
  logic          ready_q;
  logic          init_edge;

  assign init_edge = !ready_q && (init_cnt_q == INIT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else if (bus.i_clr) begin
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else if (!ready_q) begin
      if (init_cnt_q == INIT_LAST) ready_q <= 1'b1;
      else                         init_cnt_q <= init_cnt_q + IW'(1);
    end
  end

  state_t                state_q [p_CHANNELS];
  logic [CW-1:0]         cnt_q   [p_CHANNELS];
  logic [p_CHANNELS-1:0] out_q;
  logic [p_CHANNELS-1:0] rise_q;
  logic [p_CHANNELS-1:0] fall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < p_CHANNELS; c++) begin
        state_q[c] <= START;
        cnt_q[c]   <= '0;
      end
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else if (bus.i_clr) begin
      for (int unsigned c = 0; c < p_CHANNELS; c++) begin
        state_q[c] <= START;
        cnt_q[c]   <= '0;
      end
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int unsigned c = 0; c < p_CHANNELS; c++) begin
        rise_q[c] <= 1'b0;
        fall_q[c] <= 1'b0;
        case (state_q[c])
          // ready_q also releases START so a channel recovering from an illegal
          // encoding after init does not stay parked there.
          START: begin
            cnt_q[c] <= '0;
            out_q[c] <= 1'b0;
            if (init_edge || ready_q) begin
              state_q[c] <= s[c] ? HIGH : LOW;
              out_q[c]   <= s[c];
            end
          end
          LOW: begin
            out_q[c] <= 1'b0;
            cnt_q[c] <= '0;
            if (s[c]) begin
              if (p_RISE_FILTER == 1) begin
                state_q[c] <= HIGH;
                out_q[c]   <= 1'b1;
                rise_q[c]  <= 1'b1;
              end else begin
                state_q[c] <= RISE;
                cnt_q[c]   <= CNT_ONE;
              end
            end
          end
          RISE: begin
            if (!s[c]) begin
              state_q[c] <= LOW;
              cnt_q[c]   <= '0;
            end else if (cnt_q[c] == RISE_LAST) begin
              state_q[c] <= HIGH;
              cnt_q[c]   <= '0;
              out_q[c]   <= 1'b1;
              rise_q[c]  <= 1'b1;
            end else begin
              cnt_q[c] <= cnt_q[c] + CNT_ONE;
            end
          end
          HIGH: begin
            out_q[c] <= 1'b1;
            cnt_q[c] <= '0;
            if (!s[c]) begin
              if (p_FALL_FILTER == 1) begin
                state_q[c] <= LOW;
                out_q[c]   <= 1'b0;
                fall_q[c]  <= 1'b1;
              end else begin
                state_q[c] <= FALL;
                cnt_q[c]   <= CNT_ONE;
              end
            end
          end
          FALL: begin
            if (s[c]) begin
              state_q[c] <= HIGH;
              cnt_q[c]   <= '0;
            end else if (cnt_q[c] == FALL_LAST) begin
              state_q[c] <= LOW;
              cnt_q[c]   <= '0;
              out_q[c]   <= 1'b0;
              fall_q[c]  <= 1'b1;
            end else begin
              cnt_q[c] <= cnt_q[c] + CNT_ONE;
            end
          end
          default: begin
            state_q[c] <= START;
            cnt_q[c]   <= '0;
            out_q[c]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_out   = out_q;
  assign bus.o_rise  = rise_q;
  assign bus.o_fall  = fall_q;
  assign bus.o_ready = ready_q;

endmodule
